cva6_hpdcache_fence_ctrl: RTL

Sequencer that turns a fence / fence.i from the CVA6 commit controller into an ordered flush of the write-back HPDcache. It holds the load/store unit and waits for all outstanding stores to drain. It then requests a full flush (and, if configured, an invalidation), pulses the I-cache flush for fence.i, and acknowledges. It sits between the controller, the LSU store path and the HPDcache CMO/flush port.

---
 rtl/cva6_hpdcache_fence_ctrl_pkg.sv | 27 ++
 rtl/cva6_store_credit_cnt.sv | 42 ++++
 rtl/cva6_hpdcache_fence_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/cva6_hpdcache_fence_ctrl_pkg.sv
// rtl/cva6_hpdcache_fence_ctrl_pkg.sv - shared config and fence sequencer state definitions
package cva6_hpdcache_fence_ctrl_pkg;

  // Core configuration fields that steer the fence sequencer
  typedef struct packed {
    logic        DcacheFlushOnFence;
    logic        DcacheInvalidateOnFlush;
    int unsigned MaxOutstandingStores;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg = '{
    DcacheFlushOnFence:      1'b1,
    DcacheInvalidateOnFlush: 1'b0,
    MaxOutstandingStores:    7
  };

  // Fence sequencer state encoding, kept as plain constants for legacy tools
  typedef logic [2:0] fence_ctrl_state_e;

  localparam fence_ctrl_state_e FENCE_IDLE   = 3'd0;
  localparam fence_ctrl_state_e FENCE_DRAIN  = 3'd1;
  localparam fence_ctrl_state_e FENCE_FLUSH  = 3'd2;
  localparam fence_ctrl_state_e FENCE_INVAL  = 3'd3;
  localparam fence_ctrl_state_e FENCE_ICACHE = 3'd4;
  localparam fence_ctrl_state_e FENCE_DONE   = 3'd5;

endpackage

// File: rtl/cva6_store_credit_cnt.sv
// rtl/cva6_store_credit_cnt.sv - saturating outstanding-store counter with stall flag
module cva6_store_credit_cnt #(
  parameter int unsigned MaxOutstandingStores = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic st_issue_i,
  input  logic st_done_i,
  output logic stall_o,
  output logic empty_o
);

  localparam int unsigned CntW = $clog2(MaxOutstandingStores + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstandingStores);

  logic [CntW-1:0] count_q;
  logic            inc;
  logic            dec;

  // A simultaneous issue and response cancel out
  assign inc = st_issue_i & ~st_done_i;
  assign dec = st_done_i & ~st_issue_i;

  // Up/down count that holds at both ends instead of wrapping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc && (count_q != MaxCnt)) begin
      count_q <= count_q + CntW'(1);
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CntW'(1);
    end
  end

  assign stall_o = (count_q == MaxCnt);
  assign empty_o = (count_q == '0);

  // Issuing past the credit limit or retiring a store that never issued is an LSU bug
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(inc && (count_q == MaxCnt)));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(dec && (count_q == '0)));

endmodule

// File: rtl/cva6_hpdcache_fence_ctrl.sv
// rtl/cva6_hpdcache_fence_ctrl.sv - fence / fence.i sequencer: drain stores, flush D-cache, flush I-cache
module cva6_hpdcache_fence_ctrl
  import cva6_hpdcache_fence_ctrl_pkg::*;
#(
  parameter bit          FlushOnFence         = cva6_cfg.DcacheFlushOnFence,
  parameter bit          InvalidateOnFlush    = cva6_cfg.DcacheInvalidateOnFlush,
  parameter int unsigned MaxOutstandingStores = cva6_cfg.MaxOutstandingStores
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fence_req_i,
  input  logic fence_i_i,
  output logic fence_ack_o,
  output logic busy_o,
  output logic lsu_hold_o,
  input  logic st_issue_i,
  input  logic st_done_i,
  output logic st_stall_o,
  input  logic sb_empty_i,
  output logic flush_req_o,
  input  logic flush_ack_i,
  output logic inval_req_o,
  input  logic inval_ack_i,
  output logic icache_flush_o
);

  fence_ctrl_state_e state_q;
  fence_ctrl_state_e state_d;
  logic              fence_i_q;
  logic              st_empty;

  cva6_store_credit_cnt #(
    .MaxOutstandingStores(MaxOutstandingStores)
  ) i_store_credit_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .st_issue_i(st_issue_i),
    .st_done_i (st_done_i),
    .stall_o   (st_stall_o),
    .empty_o   (st_empty)
  );

  // Next-state: each step only advances on its own handshake, stray acks are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      FENCE_IDLE: begin
        if (fence_req_i) state_d = FENCE_DRAIN;
      end
      FENCE_DRAIN: begin
        if (sb_empty_i && st_empty) begin
          if (FlushOnFence)   state_d = FENCE_FLUSH;
          else if (fence_i_q) state_d = FENCE_ICACHE;
          else                state_d = FENCE_DONE;
        end
      end
      FENCE_FLUSH: begin
        if (flush_ack_i) begin
          if (InvalidateOnFlush) state_d = FENCE_INVAL;
          else if (fence_i_q)    state_d = FENCE_ICACHE;
          else                   state_d = FENCE_DONE;
        end
      end
      FENCE_INVAL: begin
        if (inval_ack_i) state_d = fence_i_q ? FENCE_ICACHE : FENCE_DONE;
      end
      FENCE_ICACHE: state_d = FENCE_DONE;
      FENCE_DONE:   state_d = FENCE_IDLE;
      default:      state_d = FENCE_IDLE;
    endcase
  end

  // State register; the fence.i flavour is captured as the request is accepted
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= FENCE_IDLE;
      fence_i_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == FENCE_IDLE) && fence_req_i) fence_i_q <= fence_i_i;
    end
  end

  assign busy_o         = (state_q != FENCE_IDLE);
  assign lsu_hold_o     = busy_o;
  assign flush_req_o    = (state_q == FENCE_FLUSH);
  assign inval_req_o    = (state_q == FENCE_INVAL);
  assign icache_flush_o = (state_q == FENCE_ICACHE);
  assign fence_ack_o    = (state_q == FENCE_DONE);

endmodule
